// File: rtl/apb_master_nslave_if.sv
// Command/response channel and APB4 bus bundle for apb_master_nslave.
// The master modport is the bridge side; slave is the requester/fabric side.
interface apb_master_nslave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic                             cmd_write;
    logic [ADDR_WIDTH-1:0]            cmd_addr;
    logic [DATA_WIDTH-1:0]            cmd_wdata;
    logic [DATA_WIDTH/8-1:0]          cmd_strb;
    logic                             rsp_valid;
    logic [DATA_WIDTH-1:0]            rsp_rdata;
    logic                             rsp_err;
    logic [NUM_SLAVES-1:0]            PSEL;
    logic                             PENABLE;
    logic                             PWRITE;
    logic [ADDR_WIDTH-1:0]            PADDR;
    logic [DATA_WIDTH-1:0]            PWDATA;
    logic [DATA_WIDTH/8-1:0]          PSTRB;
    logic [NUM_SLAVES-1:0]            PREADY;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]            PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  PREADY, PRDATA, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output PREADY, PRDATA, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );
endinterface

// File: rtl/apb_master_nslave.sv
// APB4 master bridging a valid/ready command channel to NUM_SLAVES
// address-decoded slaves, with decode-error and wait-state timeout handling.
module apb_master_nslave #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_SLAVES      = 4,
    parameter int SLAVE_ADDR_BITS = 12,
    parameter int TIMEOUT         = 256
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_nslave_if.master bus
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [IW-1:0]         idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         strb_q;
    logic                  write_q;
    logic [CW-1:0]         cnt_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic [ADDR_WIDTH-1:0] slot;
    logic                  hit;
    logic                  rdy_sel;
    logic                  err_sel;
    logic [DATA_WIDTH-1:0] rdata_sel;
    logic [NUM_SLAVES-1:0] onehot;
    logic                  ready;
    logic                  accept;
    logic                  done;
    logic                  abort;

    assign slot      = bus.cmd_addr >> SLAVE_ADDR_BITS;
    assign hit       = slot < ADDR_WIDTH'(NUM_SLAVES);
    assign rdy_sel   = bus.PREADY[idx_q];
    assign err_sel   = bus.PSLVERR[idx_q];
    assign rdata_sel = bus.PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign onehot    = NUM_SLAVES'(1) << idx_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE:   ready = 1'b1;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (rdy_sel) begin
                    done    = 1'b1;
                    ready   = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT != 0 && cnt_q == TLIM) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            DERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Never advertise ready while reset is being applied.
        ready  = ready & ~PRESET;
        accept = bus.cmd_valid & ready;
        if (accept) state_d = hit ? SETUP : DERR;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            idx_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                idx_q   <= slot[IW-1:0];
                addr_q  <= bus.cmd_addr;
                write_q <= bus.cmd_write;
                wdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
                strb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
            end
            if (state_q == SETUP) begin
                cnt_q <= '0;
            end else if (state_q == ACCESS && !rdy_sel && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (done) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_sel;
                rsp_rdata_q <= write_q ? '0 : rdata_sel;
            end else if (abort || state_q == DERR) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.PSEL      = (state_q == SETUP || state_q == ACCESS) ? onehot : '0;
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.PWRITE    = write_q;
    assign bus.PADDR     = addr_q;
    assign bus.PWDATA    = wdata_q;
    assign bus.PSTRB     = strb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule
